sha_solution_reader: RTL and testbench
======================================

SHA_SOLUTION_READER -- requirements
Module: sha_solution_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning solution-record FIFO depth (power of two, 2..16).
REQ-002 SHALL have port CLK  input  1  the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port valid_in  input  1  solution-valid level from the hasher (valid_out).
REQ-005 SHALL have port time_in  input  32  solution time word (hasher time_out).
REQ-006 SHALL have port nonce_in  input  32  solution nonce (hasher nonce_out).
REQ-007 SHALL have port result_in  input  256  solution hash (hasher result_out).
REQ-008 SHALL have port rd_valid  output  1  word-stream valid to the host.
REQ-009 SHALL have port rd_ready  input  1  word-stream ready from the host.
REQ-010 SHALL have port rd_data  output  32  current stream word.
REQ-011 SHALL have port rd_last  output  1  marks the final word of a record.
REQ-012 SHALL have port fifo_count  output  $clog2(DEPTH)+1  number of records held, including the one being streamed.
REQ-013 SHALL have port overflow  output  1  sticky flag, set when a solution is dropped.

Function
REQ-014 SHALL capture a record {time_in, nonce_in, result_in} only on a rising edge of valid_in (valid_in=1 and the registered previous value=0); a held-high valid_in yields exactly one record.
REQ-015 SHALL write the captured record into the FIFO at the same clock edge the rising edge is sampled.
REQ-016 SHALL, when the FIFO is full and no pop occurs that cycle, drop the record, leave contents unchanged and set overflow.
REQ-017 SHALL, when the FIFO is full and the final word is accepted in the same cycle, accept the new record (pop and push together, count unchanged).
REQ-018 SHALL stream each record as exactly 10 words: word0=time, word1=nonce, words2..9=result[255:224] down to result[31:0].
REQ-019 SHALL implement a read FSM with states IDLE and SEND plus a 4-bit word index 0..9.
REQ-020 SHALL move IDLE->SEND on the cycle after the FIFO becomes non-empty, with index=0; rd_valid=1 throughout SEND.
REQ-021 SHALL hold rd_data and rd_last stable while rd_valid=1 and rd_ready=0.
REQ-022 SHALL advance the index on each cycle with rd_valid & rd_ready; rd_last=1 exactly when index=9.
REQ-023 SHALL, on acceptance of word 9, pop the FIFO and go to index 0 of the next record with no bubble if one is present, else to IDLE.
REQ-024 SHALL give a latency of one cycle from the capturing edge to rd_valid=1 when IDLE with an empty FIFO.
REQ-025 SHALL drive rd_data=0 and rd_last=0 while rd_valid=0.
REQ-026 SHALL wrap FIFO read/write pointers modulo DEPTH.

Reset
REQ-027 SHALL, when RST=1 at a clock edge, empty the FIFO, enter IDLE, clear the index, the previous-valid register, overflow, rd_valid, rd_data, rd_last and fifo_count.
REQ-028 SHALL abort any record mid-stream on reset; no partial record resumes afterwards.
REQ-029 SHALL treat valid_in=1 on the first cycle after reset release as a rising edge.
REQ-030 SHALL ignore valid_in while RST=1.

Configuration
REQ-031 SHALL, with SOLN_DROP_CNT_EN defined, provide output drop_count (16 bits) counting dropped records, saturating at 0xFFFF and cleared by reset.
REQ-032 SHALL, without SOLN_DROP_CNT_EN, have no drop_count port and no counter logic; overflow behaviour is unchanged.

Structure
REQ-033 SHALL take SOLN_WORDS=10, the soln_rec_t record typedef (time, nonce, result) and the word-index typedef from shared package sha_miner_pkg.
REQ-034 SHALL instantiate the record storage as one sub-module soln_fifo (push, pop, full, empty, count; synchronous active-high reset).

Verification
REQ-035 SHALL cover: single solution -- valid_in high 2 cycles with time=130dae51, nonce=3aeb9bb8, result=5C8AD782...2701000000000000, rd_ready=1 -> one record of 10 words 130dae51, 3aeb9bb8, 5C8AD782, ..., 00000000; rd_last on word 10; fifo_count back to 0.
REQ-036 SHALL cover: back-pressure -- rd_ready=0 for 5 cycles mid-record at word 3 -> rd_data stays 3F8DB735, index does not advance, no word lost or duplicated.
REQ-037 SHALL cover: overflow -- DEPTH=4, rd_ready=0, 5 distinct valid_in pulses (nonces 1..5) -> fifo_count=4, overflow=1, drop_count=1 (macro on), stream yields nonces 1..4 in order.
REQ-038 SHALL cover: simultaneous full push and final-word pop -> new record kept, fifo_count stays 4, overflow stays 0.
REQ-039 SHALL cover: reset asserted at word 5 -> next cycle rd_valid=0, fifo_count=0, overflow=0; a later pulse streams from word0.
REQ-040 SHALL cover: back-to-back records with rd_ready=1 -> 20 consecutive valid words, no idle cycle between word 9 and next word 0.

Source files
------------

// File: rtl/sha_miner_pkg.sv
// sha_miner_pkg: shared solution-record types, stream word count and word selector
// Items: SOLN_WORDS (words per record), word_idx_t, soln_rec_t, rd_state_t, LAST_IDX, rec_word()
package sha_miner_pkg;
  localparam int SOLN_WORDS = 10;
  typedef logic [3:0] word_idx_t;
  typedef struct packed {
    logic [31:0]  time_word;
    logic [31:0]  nonce;
    logic [255:0] result;
  } soln_rec_t;
  typedef enum logic {IDLE, SEND} rd_state_t;
  localparam word_idx_t LAST_IDX = word_idx_t'(SOLN_WORDS - 1);
  // The packed record already lies in stream order from its MSB down, so
  // word k is the top 32 bits after shifting k words out.
  function automatic logic [31:0] rec_word(soln_rec_t rec, word_idx_t idx);
    logic [319:0] s;
    s = rec;
    s = s << (32 * idx);
    return s[319:288];
  endfunction
endpackage

// File: rtl/sha_solution_reader_fifo.sv
// soln_fifo: DEPTH-entry solution-record FIFO with synchronous active-high reset
// Ports: clk, rst; push/wdata write (ignored when full unless popping); pop/rdata read head;
//        full, empty, count (records held)
module soln_fifo
  import sha_miner_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  soln_rec_t                wdata,
  output soln_rec_t                rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  soln_rec_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // A full FIFO still takes a write when the head leaves on the same edge.
  assign wr    = push & (~full | pop);
  assign rd    = pop & ~empty;
  assign rdata = mem[rp];
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/sha_solution_reader.sv
// sha_solution_reader: captures hasher solutions on valid_in rising edges and streams them as 10-word records
// Ports: CLK, RST (sync, active-high); valid_in/time_in/nonce_in/result_in from the hasher;
//        rd_valid/rd_ready/rd_data/rd_last word stream; fifo_count; sticky overflow;
//        drop_count (16-bit saturating) only when SOLN_DROP_CNT_EN is defined
module sha_solution_reader
  import sha_miner_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     valid_in,
  input  logic [31:0]              time_in,
  input  logic [31:0]              nonce_in,
  input  logic [255:0]             result_in,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [31:0]              rd_data,
  output logic                     rd_last,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
`ifdef SOLN_DROP_CNT_EN
  ,
  output logic [15:0]              drop_count
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  rd_state_t state_q, state_d;
  word_idx_t idx_q, idx_d;
  soln_rec_t head;
  logic prev_valid, rise, last, pop, full, empty, drop;
  assign rise     = valid_in & ~prev_valid;
  assign rd_valid = state_q == SEND;
  assign last     = rd_valid && idx_q == LAST_IDX;
  assign pop      = last & rd_ready;
  assign drop     = rise & full & ~pop;
  assign rd_last  = last;
  assign rd_data  = rd_valid ? rec_word(head, idx_q) : '0;
  soln_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (rise),
    .pop   (pop),
    .wdata ({time_in, nonce_in, result_in}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
  // Stay in SEND across a pop whenever another record remains, including one
  // pushed on the very edge the last remaining record leaves.
  always_comb begin
    state_d = state_q == IDLE ? (empty ? IDLE : SEND)
            : (pop && fifo_count == CW'(1) && !rise) ? IDLE : SEND;
    idx_d   = (rd_valid && rd_ready) ? (last ? '0 : idx_q + 1'b1) : idx_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      prev_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      prev_valid <= valid_in;
      overflow   <= overflow | drop;
    end
  end
`ifdef SOLN_DROP_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_sha_solution_reader.sv
// tb_sha_solution_reader: directed self-checking bench for sha_solution_reader (DEPTH=4)
module tb_sha_solution_reader;
  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         valid_in = 1'b0;
  logic [31:0]  time_in = '0;
  logic [31:0]  nonce_in = '0;
  logic [255:0] result_in = '0;
  logic         rd_valid;
  logic         rd_ready = 1'b0;
  logic [31:0]  rd_data;
  logic         rd_last;
  logic [2:0]   fifo_count;
  logic         overflow;
`ifdef SOLN_DROP_CNT_EN
  logic [15:0]  drop_count;
`endif
  int checks = 0;
  int errors = 0;
  logic [31:0] w1 [10] = '{32'h130dae51, 32'h3aeb9bb8, 32'h5C8AD782, 32'h3F8DB735,
                           32'hA1B2C3D4, 32'h11223344, 32'h55667788, 32'h99AABBCC,
                           32'h27010000, 32'h00000000};
  logic [31:0] w2 [10] = '{32'hDEADBEEF, 32'h0BADF00D, 32'h10000002, 32'h10000003,
                           32'h10000004, 32'h10000005, 32'h10000006, 32'h10000007,
                           32'h10000008, 32'h10000009};
  logic [255:0] res1, res2;

  always #5 CLK = ~CLK;

  sha_solution_reader #(.DEPTH(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .valid_in   (valid_in),
    .time_in    (time_in),
    .nonce_in   (nonce_in),
    .result_in  (result_in),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .fifo_count (fifo_count),
    .overflow   (overflow)
`ifdef SOLN_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    valid_in = 1'b0;
    rd_ready = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] t, input logic [31:0] n, input logic [255:0] r);
    valid_in = 1'b1;
    time_in = t;
    nonce_in = n;
    result_in = r;
    tick();
    valid_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last got %b want 0", rd_last); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    RST = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    rd_ready = 1'b1;
    valid_in = 1'b1;
    time_in = w1[0];
    nonce_in = w1[1];
    result_in = res1;
    tick();
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count_after_capture got %0d want 1", fifo_count); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early got %b want 0", rd_valid); end
    tick();
    valid_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL single_valid w%0d got %b want 1", k, rd_valid); end
      checks++; if (rd_data !== w1[k]) begin errors++; $display("FAIL single_data w%0d got %h want %h", k, rd_data, w1[k]); end
      checks++; if (rd_last !== (k == 9)) begin errors++; $display("FAIL single_last w%0d got %b want %b", k, rd_last, k == 9); end
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_idle c%0d got %b want 0", c, rd_valid); end
      checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL single_idle_data c%0d got %h want 0", c, rd_data); end
      tick();
    end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_count_end got %0d want 0", fifo_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    rd_ready = 1'b1;
    pulse(w1[0], w1[1], res1);
    for (int k = 0; k < 10; k++) begin
      checks++; if (rd_data !== w1[k]) begin errors++; $display("FAIL bp_data w%0d got %h want %h", k, rd_data, w1[k]); end
      checks++; if (rd_last !== (k == 9)) begin errors++; $display("FAIL bp_last w%0d got %b want %b", k, rd_last, k == 9); end
      if (k == 3) begin
        rd_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          tick();
          checks++; if (rd_data !== 32'h3F8DB735) begin errors++; $display("FAIL bp_hold c%0d got %h want 3f8db735", c, rd_data); end
          checks++; if (rd_valid !== 1'b1 || rd_last !== 1'b0) begin errors++; $display("FAIL bp_hold_flags c%0d got v%b l%b want v1 l0", c, rd_valid, rd_last); end
        end
        rd_ready = 1'b1;
      end
      tick();
    end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got %b want 0", rd_valid); end
  endtask

  task automatic test_overflow();
    logic [31:0] e;
    do_reset();
    for (int i = 1; i <= 5; i++) pulse(32'h10000000 + i, i, 256'(i));
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
`ifdef SOLN_DROP_CNT_EN
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL ovf_drop_count got %0d want 1", drop_count); end
`endif
    rd_ready = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      for (int k = 0; k < 10; k++) begin
        e = k == 0 ? 32'h10000000 + r : (k == 1 || k == 9) ? r : 32'h0;
        checks++; if (rd_data !== e || rd_valid !== 1'b1) begin errors++; $display("FAIL ovf_stream r%0d w%0d got %h v%b want %h v1", r, k, rd_data, rd_valid, e); end
        tick();
      end
    end
    checks++; if (rd_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL ovf_drain got v%b n%0d want v0 n0", rd_valid, fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_full_pop();
    logic [31:0] e;
    do_reset();
    for (int i = 1; i <= 4; i++) pulse(32'h20000000 + i, 32'h20 + i, 256'(i));
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fp_count_full got %0d want 4", fifo_count); end
    rd_ready = 1'b1;
    repeat (9) tick();
    checks++; if (rd_last !== 1'b1 || rd_data !== 32'h1) begin errors++; $display("FAIL fp_last got l%b %h want l1 00000001", rd_last, rd_data); end
    valid_in = 1'b1;
    time_in = 32'h20000005;
    nonce_in = 32'h25;
    result_in = 256'(5);
    tick();
    valid_in = 1'b0;
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fp_count_swap got %0d want 4", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fp_overflow got %b want 0", overflow); end
    for (int r = 2; r <= 5; r++) begin
      for (int k = 0; k < 10; k++) begin
        e = k == 0 ? 32'h20000000 + r : k == 1 ? 32'h20 + r : k == 9 ? r : 32'h0;
        checks++; if (rd_data !== e || rd_valid !== 1'b1) begin errors++; $display("FAIL fp_stream r%0d w%0d got %h v%b want %h v1", r, k, rd_data, rd_valid, e); end
        tick();
      end
    end
    checks++; if (rd_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL fp_drain got v%b n%0d want v0 n0", rd_valid, fifo_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 5; i++) pulse(32'h30000000 + i, i, 256'(i));
    rd_ready = 1'b1;
    repeat (5) tick();
    checks++; if (rd_data !== 32'h0 || rd_valid !== 1'b1) begin errors++; $display("FAIL rm_word5 got %h v%b want 0 v1", rd_data, rd_valid); end
    RST = 1'b1;
    valid_in = 1'b1;
    time_in = w2[0];
    nonce_in = w2[1];
    result_in = res2;
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b want 0", rd_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rm_count got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rm_overflow got %b want 0", overflow); end
    tick();
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rm_ignore_in_reset got %0d want 0", fifo_count); end
    RST = 1'b0;
    tick();
    checks++; if (fifo_count !== 3'd1 || rd_valid !== 1'b0) begin errors++; $display("FAIL rm_first_cycle_edge got n%0d v%b want n1 v0", fifo_count, rd_valid); end
    valid_in = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      checks++; if (rd_data !== w2[k] || rd_valid !== 1'b1) begin errors++; $display("FAIL rm_stream w%0d got %h v%b want %h v1", k, rd_data, rd_valid, w2[k]); end
      tick();
    end
    checks++; if (rd_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL rm_end got v%b n%0d want v0 n0", rd_valid, fifo_count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    do_reset();
    pulse(w1[0], w1[1], res1);
    pulse(w2[0], w2[1], res2);
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL b2b_count got %0d want 2", fifo_count); end
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      e = i < 10 ? w1[i] : w2[i-10];
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid i%0d got %b want 1", i, rd_valid); end
      checks++; if (rd_data !== e) begin errors++; $display("FAIL b2b_data i%0d got %h want %h", i, rd_data, e); end
      checks++; if (rd_last !== (i % 10 == 9)) begin errors++; $display("FAIL b2b_last i%0d got %b want %b", i, rd_last, i % 10 == 9); end
      tick();
    end
    checks++; if (rd_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL b2b_end got v%b n%0d want v0 n0", rd_valid, fifo_count); end
  endtask

  initial begin
    res1 = {w1[2], w1[3], w1[4], w1[5], w1[6], w1[7], w1[8], w1[9]};
    res2 = {w2[2], w2[3], w2[4], w2[5], w2[6], w2[7], w2[8], w2[9]};
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
